// File: rtl/mem_arbiter_if.sv
// Native PicoRV32-style memory bus (valid/ready handshake) between one requester and one responder.
interface mem_arbiter_if;
  logic        valid;
  logic        instr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        ready;
  logic [31:0] rdata;

  modport master (
    output valid, instr, addr, wdata, wstrb,
    input  ready, rdata
  );

  modport slave (
    input  valid, instr, addr, wdata, wstrb,
    output ready, rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter onto one PicoRV32-native memory slave; port 0 = CPU, port 1 = loader/DMA.
// Optional stuck-slave timeout enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter #(
  parameter int unsigned FIXED_PRIO     = 0,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  m0,
  mem_arbiter_if.slave  m1,
  mem_arbiter_if.master mem,
  output logic [1:0]    grant,
  output logic          timeout
);

  typedef enum logic [1:0] {StIdle, StGnt0, StGnt1} state_e;

  state_e state_q, state_d;
  logic   last_q, last_d;  // 1: port 1 was served last
  logic   own0, own1, own_valid, fire, done;

  if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("mem_arbiter: TIMEOUT_CYCLES must be in 1..65535");
  end

  assign own0      = (state_q == StGnt0);
  assign own1      = (state_q == StGnt1);
  assign own_valid = (own0 & m0.valid) | (own1 & m1.valid);
  assign grant     = {own1, own0};

  // Owner's request is forwarded combinationally; a dropped owner valid drops mem.valid at once.
  always_comb begin
    mem.valid = own_valid & ~fire;
    mem.instr = 1'b0;
    mem.addr  = '0;
    mem.wdata = '0;
    mem.wstrb = '0;
    if (own0) begin
      mem.instr = m0.instr;
      mem.addr  = m0.addr;
      mem.wdata = m0.wdata;
      mem.wstrb = m0.wstrb;
    end else if (own1) begin
      mem.instr = m1.instr;
      mem.addr  = m1.addr;
      mem.wdata = m1.wdata;
      mem.wstrb = m1.wstrb;
    end
  end

  assign done     = (mem.ready & mem.valid) | fire;
  assign m0.ready = own0 & done;
  assign m1.ready = own1 & done;
  assign m0.rdata = (own0 & fire) ? 32'hDEAD_BEEF : mem.rdata;
  assign m1.rdata = (own1 & fire) ? 32'hDEAD_BEEF : mem.rdata;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      StIdle: begin
        if (m0.valid && m1.valid) begin
          state_d = (FIXED_PRIO != 0 || last_q) ? StGnt0 : StGnt1;
        end else if (m0.valid) begin
          state_d = StGnt0;
        end else if (m1.valid) begin
          state_d = StGnt1;
        end
      end
      StGnt0, StGnt1: begin
        if (!own_valid) begin
          state_d = StIdle;
        end else if (done) begin
          state_d = StIdle;
          last_d  = own1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam logic [15:0] TimeoutCnt = 16'(TIMEOUT_CYCLES);

  logic [15:0] cnt_q, cnt_d;
  logic        arm_q, arm_d, stall;

  // arm_q marks that the count hit the limit last cycle; expiry fires one cycle later.
  assign stall   = own_valid & ~mem.ready;
  assign fire    = arm_q & stall;
  assign timeout = fire;

  always_comb begin
    cnt_d = '0;
    arm_d = 1'b0;
    if (stall && !fire) begin
      cnt_d = cnt_q + 16'd1;
      arm_d = (cnt_q == TimeoutCnt);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      arm_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      arm_q <= arm_d;
    end
  end
`else
  assign fire    = 1'b0;
  assign timeout = 1'b0;
`endif

endmodule
